// File: rtl/arm_reg_file.sv
// rtl/arm_reg_file.sv - 16-entry register file with ARM PC read semantics and three registered read ports
// Define ARM_REG_FILE_BYPASS_EN to forward same-cycle writes to the read ports.
module arm_reg_file #(
    parameter int                WIDTH    = 32,
    parameter int                AW       = 4,
    parameter logic [WIDTH-1:0]  PC_RESET = '0,
    parameter logic [WIDTH-1:0]  PC_AHEAD = WIDTH'(8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    input  logic [AW-1:0]    rc_addr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pc_wr_en,
    input  logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    output logic [WIDTH-1:0] rc_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] pc
);

    localparam int             NREGS  = 2 ** AW;
    localparam logic [AW-1:0]  PC_IDX = '1;

    // The top entry of regs_q is never written; the PC lives in pc_q instead.
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rc_q, rc_d;
    logic             valid_q, valid_d;

    function automatic logic [WIDTH-1:0] read_value(input logic [AW-1:0] addr);
        logic [WIDTH-1:0] v;
        v = (addr == PC_IDX) ? pc_q + PC_AHEAD : regs_q[addr];
`ifdef ARM_REG_FILE_BYPASS_EN
        // Forward the write-port value; a concurrent fetch-side PC load is not forwarded.
        if (wr_en && (wr_addr == addr)) begin
            v = (addr == PC_IDX) ? wr_data + PC_AHEAD : wr_data;
        end
`endif
        return v;
    endfunction

    always_comb begin
        regs_d  = regs_q;
        pc_d    = pc_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        valid_d = rd_en;

        if (wr_en && (wr_addr != PC_IDX)) begin
            regs_d[wr_addr] = wr_data;
        end

        // Branch via the write port beats the sequential fetch update.
        if (wr_en && (wr_addr == PC_IDX)) begin
            pc_d = wr_data;
        end else if (pc_wr_en) begin
            pc_d = pc_next;
        end

        if (rd_en) begin
            ra_d = read_value(ra_addr);
            rb_d = read_value(rb_addr);
            rc_d = read_value(rc_addr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pc_q    <= PC_RESET;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
        end
    end

    assign ra_data  = ra_q;
    assign rb_data  = rb_q;
    assign rc_data  = rc_q;
    assign rd_valid = valid_q;
    assign pc       = pc_q;

endmodule

// File: tb/tb_arm_reg_file.sv
// tb/tb_arm_reg_file.sv - directed and randomized checks of arm_reg_file against an architectural model
module tb_arm_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic [3:0]  ra_addr, rb_addr, rc_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pc_wr_en;
    logic [31:0] pc_next;
    logic [31:0] ra_data, rb_data, rc_data, pc;
    logic        rd_valid;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model: register contents, PC, and the last values read out.
    logic [31:0] m_r [16];
    logic [31:0] m_pc;
    logic [31:0] exp_a, exp_b, exp_c;
    logic        exp_v;

    arm_reg_file dut (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .ra_addr  (ra_addr),
        .rb_addr  (rb_addr),
        .rc_addr  (rc_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .pc_wr_en (pc_wr_en),
        .pc_next  (pc_next),
        .ra_data  (ra_data),
        .rb_data  (rb_data),
        .rc_data  (rc_data),
        .rd_valid (rd_valid),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [3:0] a);
`ifdef ARM_REG_FILE_BYPASS_EN
        if (wr_en && wr_addr == a) return (a == 4'd15) ? wr_data + 32'd8 : wr_data;
`endif
        return (a == 4'd15) ? m_pc + 32'd8 : m_r[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc  = '0;
        exp_a = '0;
        exp_b = '0;
        exp_c = '0;
        exp_v = 1'b0;
    endtask

    task automatic idle();
        rd_en = 0; wr_en = 0; pc_wr_en = 0;
        ra_addr = 0; rb_addr = 0; rc_addr = 0;
        wr_addr = 0; wr_data = 0; pc_next = 0;
    endtask

    // Advance one clock with the current inputs, updating the model alongside.
    task automatic cycle();
        exp_v = rd_en;
        if (rd_en) begin
            exp_a = model_read(ra_addr);
            exp_b = model_read(rb_addr);
            exp_c = model_read(rc_addr);
        end
        if (wr_en && wr_addr == 4'd15) m_pc = wr_data;
        else if (pc_wr_en) m_pc = pc_next;
        if (wr_en && wr_addr != 4'd15) m_r[wr_addr] = wr_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr_en = 1; wr_addr = 4'd3; wr_data = 32'hCAFE_0003;
        pc_wr_en = 1; pc_next = 32'h40;
        cycle();
        idle();
        rd_en = 1; ra_addr = 4'd3; rb_addr = 4'd15; rc_addr = 4'd3;
        cycle();
        idle();
        #3 rst = 1'b1;
        model_reset();
        #2;
        n_cmp++;
        if ({ra_data, rb_data, rc_data, rd_valid, pc} !== {96'd0, 1'b0, 32'd0}) begin
            n_err++;
            $display("FAIL async_reset: got ra=%h rb=%h rc=%h v=%b pc=%h required all 0", ra_data, rb_data, rc_data, rd_valid, pc);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rd_en = 1; ra_addr = 4'd3; rb_addr = 4'd3; rc_addr = 4'd3;
        cycle();
        n_cmp++;
        if ({ra_data, rb_data, rc_data, rd_valid} !== {96'd0, 1'b1}) begin
            n_err++;
            $display("FAIL post_reset_read: got ra=%h rb=%h rc=%h v=%b required 0/0/0 v=1", ra_data, rb_data, rc_data, rd_valid);
        end
        idle();
    endtask

    task automatic test_basic();
        wr_en = 1; wr_addr = 4'd1; wr_data = 32'hDEAD_BEEF;
        cycle();
        wr_addr = 4'd2; wr_data = 32'h1234_5678;
        cycle();
        idle();
        rd_en = 1; ra_addr = 4'd1; rb_addr = 4'd2; rc_addr = 4'd1;
        cycle();
        n_cmp++;
        if ({ra_data, rb_data, rc_data, rd_valid} !== {32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1}) begin
            n_err++;
            $display("FAIL basic_read: got ra=%h rb=%h rc=%h v=%b required deadbeef/12345678/deadbeef v=1", ra_data, rb_data, rc_data, rd_valid);
        end
        idle();
        cycle();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_pulse: got rd_valid=%b required 0", rd_valid);
        end
    endtask

    task automatic test_pc_offset();
        pc_wr_en = 1; pc_next = 32'h100;
        cycle();
        idle();
        rd_en = 1; ra_addr = 4'd15;
        cycle();
        n_cmp++;
        if ({ra_data, pc} !== {32'h108, 32'h100}) begin
            n_err++;
            $display("FAIL pc_offset: got ra=%h pc=%h required 108/100", ra_data, pc);
        end
        idle();
        pc_wr_en = 1; pc_next = 32'hFFFF_FFFC;
        cycle();
        idle();
        rd_en = 1; rb_addr = 4'd15;
        cycle();
        n_cmp++;
        if ({rb_data, pc} !== {32'h4, 32'hFFFF_FFFC}) begin
            n_err++;
            $display("FAIL pc_wrap: got rb=%h pc=%h required 4/fffffffc", rb_data, pc);
        end
        idle();
    endtask

    task automatic test_pc_priority();
        wr_en = 1; wr_addr = 4'd15; wr_data = 32'h2000;
        pc_wr_en = 1; pc_next = 32'h3000;
        cycle();
        n_cmp++;
        if (pc !== 32'h2000) begin
            n_err++;
            $display("FAIL pc_priority: got pc=%h required 2000", pc);
        end
        idle();
        rd_en = 1; rc_addr = 4'd15;
        cycle();
        n_cmp++;
        if (rc_data !== 32'h2008) begin
            n_err++;
            $display("FAIL pc_priority_read: got rc=%h required 2008", rc_data);
        end
        idle();
    endtask

    task automatic test_hazard();
        logic [31:0] want;
`ifdef ARM_REG_FILE_BYPASS_EN
        want = 32'h22;
`else
        want = 32'h11;
`endif
        wr_en = 1; wr_addr = 4'd4; wr_data = 32'h11;
        cycle();
        rd_en = 1; ra_addr = 4'd4; wr_data = 32'h22;
        cycle();
        n_cmp++;
        if (ra_data !== want) begin
            n_err++;
            $display("FAIL hazard_same_cycle: got ra=%h required %h", ra_data, want);
        end
        wr_en = 0;
        cycle();
        n_cmp++;
        if (ra_data !== 32'h22) begin
            n_err++;
            $display("FAIL hazard_after: got ra=%h required 22", ra_data);
        end
        idle();
    endtask

    task automatic test_hold_reset();
        rd_en = 1; ra_addr = 4'd1;
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++;
            if ({ra_data, rd_valid} !== {32'hDEAD_BEEF, 1'b0}) begin
                n_err++;
                $display("FAIL hold_%0d: got ra=%h v=%b required deadbeef v=0", i, ra_data, rd_valid);
            end
        end
        rd_en = 1; ra_addr = 4'd1;
        #8 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        n_cmp++;
        if ({ra_data, rd_valid} !== {32'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_read: got ra=%h v=%b required 0 v=0", ra_data, rd_valid);
        end
        #3 rst = 1'b0;
        idle();
        cycle();
        n_cmp++;
        if (rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release_valid: got v=%b required 0", rd_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rd_en    = ($urandom_range(0, 3) != 0);
            ra_addr  = 4'($urandom);
            rb_addr  = 4'($urandom);
            rc_addr  = 4'($urandom);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = 4'($urandom);
            wr_data  = $urandom;
            pc_wr_en = ($urandom_range(0, 2) == 0);
            pc_next  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            cycle();
            n_cmp++;
            if ({ra_data, rb_data, rc_data, rd_valid, pc} !== {exp_a, exp_b, exp_c, exp_v, m_pc}) begin
                n_err++;
                $display("FAIL random_%0d: got ra=%h rb=%h rc=%h v=%b pc=%h required ra=%h rb=%h rc=%h v=%b pc=%h",
                         i, ra_data, rb_data, rc_data, rd_valid, pc, exp_a, exp_b, exp_c, exp_v, m_pc);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pc_offset();
        test_pc_priority();
        test_hazard();
        test_hold_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
